param_fifo: RTL

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ram.sv | 33 +++
 rtl/param_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared constants and helpers for the parameterised FIFO.
//   FIFO_MODE_STD  : registered-read output (1-cycle read latency)
//   FIFO_MODE_FWFT : first-word-fall-through output
//   fifo_count_w() : width needed to hold an occupancy of 0..depth
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
//   WORD_WIDTH x DEPTH storage, one synchronous write port and one
//   asynchronous read port. Contents are not reset.
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write address (0..DEPTH-1)
//   i_wdata  : write data
//   i_raddr  : read address (0..DEPTH-1)
//   o_rdata  : combinational read data at i_raddr
module fifo_ram #(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [WORD_WIDTH-1:0] o_rdata
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/param_fifo.sv
// param_fifo
//   Single-clock FIFO with runtime thresholds and sticky error flags.
//   clk, reset             : clock, synchronous active-high reset
//   i_w_en / i_w_data      : write request and data
//   i_r_en                 : read (pop) request
//   i_afull_lvl            : almost-full threshold  (o_afull  = count >= lvl)
//   i_aempty_lvl           : almost-empty threshold (o_aempty = count <= lvl)
//   i_clr_err              : clears o_overflow / o_underflow
//   o_r_data               : read data (registered or fall-through, see FWFT)
//   o_count                : words stored, 0..DEPTH
//   o_full/o_afull/o_empty/o_aempty : status, combinational from o_count
//   o_overflow/o_underflow : sticky rejected-request flags
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int FWFT       = FIFO_MODE_STD,
    localparam int CW        = fifo_count_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_w_en,
    input  logic [WORD_WIDTH-1:0] i_w_data,
    input  logic                  i_r_en,
    input  logic [CW-1:0]         i_afull_lvl,
    input  logic [CW-1:0]         i_aempty_lvl,
    input  logic                  i_clr_err,
    output logic [WORD_WIDTH-1:0] o_r_data,
    output logic [CW-1:0]         o_count,
    output logic                  o_full,
    output logic                  o_afull,
    output logic                  o_empty,
    output logic                  o_aempty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [WORD_WIDTH-1:0] ram_rdata;
    logic                  rd_ok, wr_ok;

    // DEPTH need not be a power of two, so wrap explicitly
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_count  = count_q;
    assign o_full   = (count_q == CW'(DEPTH));
    assign o_empty  = (count_q == '0);
    assign o_afull  = (count_q >= i_afull_lvl);
    assign o_aempty = (count_q <= i_aempty_lvl);

    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write
    assign rd_ok = i_r_en && !o_empty;
    assign wr_ok = i_w_en && (!o_full || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            rdata_d  = ram_rdata;
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // set wins over clear when both happen in one cycle
        if (i_clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (i_w_en && !wr_ok) ovf_d = 1'b1;
        if (i_r_en && !rd_ok) udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (wr_ok && !reset),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_w_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (ram_rdata)
    );

    // Fall-through output is forced to zero while empty so reset leaves a
    // known value instead of whatever the RAM holds at the read pointer.
    assign o_r_data = (FWFT == FIFO_MODE_FWFT) ? (o_empty ? '0 : ram_rdata)
                                               : rdata_q;

endmodule
